// File: rtl/pipe_control_if.sv
// pipe_control_if
// Bundles the decode-side inputs and the EX-side control outputs of
// pipe_control. The SIGW/REGAW values given here must match the ones
// given to the pipe_control instance that uses this interface.
//
//   master : decode stage / ALU / EXEC unit side (drives id_*, alu_flags, exec_done)
//   slave  : pipe_control (drives stall, redirect, exec_req and the ex_* word)
//
//   id_valid, id_opcode[3:0], id_cond[2:0], id_rs/id_rt/id_rd[REGAW-1:0]
//   alu_flags[2:0] {N,V,Z}, exec_done
//   stall, redirect, exec_req, ex_valid, ex_opcode[3:0], ex_rd[REGAW-1:0],
//   ex_alu_op[2:0], ex_signal[SIGW-1:0], ex_write_en, ex_mem_en, ex_mem_write_n
interface pipe_control_if #(
    parameter int SIGW  = 12,
    parameter int REGAW = 4
);
    logic             id_valid;
    logic [3:0]       id_opcode;
    logic [2:0]       id_cond;
    logic [REGAW-1:0] id_rs;
    logic [REGAW-1:0] id_rt;
    logic [REGAW-1:0] id_rd;
    logic [2:0]       alu_flags;
    logic             exec_done;

    logic             stall;
    logic             redirect;
    logic             exec_req;
    logic             ex_valid;
    logic [3:0]       ex_opcode;
    logic [REGAW-1:0] ex_rd;
    logic [2:0]       ex_alu_op;
    logic [SIGW-1:0]  ex_signal;
    logic             ex_write_en;
    logic             ex_mem_en;
    logic             ex_mem_write_n;

    modport master (
        output id_valid, id_opcode, id_cond, id_rs, id_rt, id_rd, alu_flags, exec_done,
        input  stall, redirect, exec_req, ex_valid, ex_opcode, ex_rd, ex_alu_op,
               ex_signal, ex_write_en, ex_mem_en, ex_mem_write_n
    );

    modport slave (
        input  id_valid, id_opcode, id_cond, id_rs, id_rt, id_rd, alu_flags, exec_done,
        output stall, redirect, exec_req, ex_valid, ex_opcode, ex_rd, ex_alu_op,
               ex_signal, ex_write_en, ex_mem_en, ex_mem_write_n
    );
endinterface

// File: rtl/pipe_control.sv
// pipe_control
// Control unit between decode and the ID/EX register of the 16-bit CPU.
// Decodes the opcode into one registered control word per accepted
// instruction, keeps the {N,V,Z} flag register, resolves B/JAL/JR,
// interlocks on load-use and flag hazards and runs the EXEC handshake.
//
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : pipe_control_if.slave (decode inputs, stall/redirect, exec_req, ex_* word)
module pipe_control #(
    parameter int SIGW      = 12,
    parameter int REGAW     = 4,
    parameter int HAZARD_EN = 1
) (
    input  logic          clk,
    input  logic          rst,
    pipe_control_if.slave bus
);

    typedef enum logic [0:0] {IDLE, EXEC_WAIT} state_t;

    typedef struct packed {
        logic [11:0] sig;
        logic [2:0]  alu;
        logic        we;
        logic        me;
        logic        mwn;
    } ctl_t;

    localparam ctl_t BUBBLE = '{sig: 12'h000, alu: 3'b000, we: 1'b0, me: 1'b0, mwn: 1'b1};

    function automatic ctl_t decode_ctl(input logic [3:0] op, input logic taken);
        ctl_t c;
        c = BUBBLE;
        case (op)
            4'h0, 4'h1, 4'h2, 4'h3: begin c.sig = 12'h036; c.alu = op[2:0]; c.we = 1'b1; end
            4'h4, 4'h5, 4'h6, 4'h7: begin c.sig = 12'h016; c.alu = op[2:0]; c.we = 1'b1; end
            4'h8: begin c.sig = 12'h896; c.we = 1'b1; c.me = 1'b1; end
            4'h9: begin c.sig = 12'h930; c.me = 1'b1; c.mwn = 1'b0; end
            4'hA: begin c.sig = 12'h500; c.we = 1'b1; end
            4'hB: begin c.sig = 12'h000; c.alu = 3'b010; c.we = 1'b1; end
            4'hC: c.sig = taken ? 12'h031 : 12'h030;
            4'hD: begin c.sig = 12'h17D; c.we = 1'b1; end
            4'hE: c.sig = 12'h17F;
            default: begin c.sig = 12'h137; c.we = 1'b1; end
        endcase
        return c;
    endfunction

    // Flags are packed {N,V,Z}.
    function automatic logic cond_taken(input logic [2:0] cond, input logic [2:0] f);
        logic n, v, z;
        n = f[2];
        v = f[1];
        z = f[0];
        case (cond)
            3'b000:  return z;
            3'b001:  return !z;
            3'b010:  return !z && !n;
            3'b011:  return n;
            3'b100:  return z || (!z && !n);
            3'b101:  return z || n;
            3'b110:  return v;
            default: return 1'b1;
        endcase
    endfunction

    state_t           state, state_nxt;
    logic             kill_p1, kill_nxt;
    logic [2:0]       flags_p1;
    logic             exec_req_p1, exec_req_nxt;
    logic [REGAW-1:0] exec_rd, exec_rd_nxt;

    logic             vld_p1, vld_nxt;
    logic [3:0]       opcode_p1, opcode_nxt;
    logic [REGAW-1:0] rd_p1, rd_nxt;
    ctl_t             ctl_p1, ctl_nxt;

    logic load_use, flag_hz, hazard, taken, jump, exec_start, stall_c, redirect_c, issue;

    always_comb begin
        load_use = 1'b0;
        flag_hz  = 1'b0;
        if (HAZARD_EN != 0 && bus.id_valid) begin
            load_use = vld_p1 && (opcode_p1 == 4'h8) && (rd_p1 != '0) &&
                       ((rd_p1 == bus.id_rs) || (rd_p1 == bus.id_rt));
            flag_hz  = (bus.id_opcode == 4'hC) && vld_p1 && !opcode_p1[3];
        end
    end

    assign hazard     = load_use || flag_hz;
    assign taken      = cond_taken(bus.id_cond, flags_p1);
    assign jump       = (bus.id_opcode == 4'hD) || (bus.id_opcode == 4'hE) ||
                        ((bus.id_opcode == 4'hC) && taken);
    // EXEC holds in decode from the cycle it is recognised until exec_done,
    // so the word issued on exec_done belongs to that same instruction.
    assign exec_start = (state == IDLE) && bus.id_valid && (bus.id_opcode == 4'hF) &&
                        !hazard && !kill_p1;
    // A killed slot never stalls: the instruction in decode is being thrown away.
    assign stall_c    = !kill_p1 && (hazard || (state == EXEC_WAIT) || exec_start);
    assign redirect_c = bus.id_valid && !stall_c && !kill_p1 && jump;
    assign issue      = bus.id_valid && !stall_c && !kill_p1;

    always_comb begin
        state_nxt    = state;
        kill_nxt     = 1'b0;
        exec_req_nxt = exec_req_p1;
        exec_rd_nxt  = exec_rd;
        vld_nxt      = 1'b0;
        opcode_nxt   = 4'h0;
        rd_nxt       = '0;
        ctl_nxt      = BUBBLE;
        if (kill_p1) begin
            // discard the decode slot behind a taken branch or jump
        end else if (state == EXEC_WAIT) begin
            if (bus.exec_done) begin
                state_nxt    = IDLE;
                exec_req_nxt = 1'b0;
                vld_nxt      = 1'b1;
                opcode_nxt   = 4'hF;
                rd_nxt       = exec_rd;
                ctl_nxt      = decode_ctl(4'hF, 1'b0);
            end
        end else if (exec_start) begin
            state_nxt    = EXEC_WAIT;
            exec_req_nxt = 1'b1;
            exec_rd_nxt  = bus.id_rd;
        end else if (issue) begin
            vld_nxt    = 1'b1;
            opcode_nxt = bus.id_opcode;
            rd_nxt     = bus.id_rd;
            ctl_nxt    = decode_ctl(bus.id_opcode, taken);
            kill_nxt   = redirect_c;
        end
    end

    // ---- ID -> EX register boundary ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            kill_p1     <= 1'b0;
            flags_p1    <= 3'b000;
            exec_req_p1 <= 1'b0;
            vld_p1      <= 1'b0;
            opcode_p1   <= 4'h0;
            rd_p1       <= '0;
            ctl_p1      <= BUBBLE;
        end else begin
            state       <= state_nxt;
            kill_p1     <= kill_nxt;
            exec_req_p1 <= exec_req_nxt;
            vld_p1      <= vld_nxt;
            opcode_p1   <= opcode_nxt;
            rd_p1       <= rd_nxt;
            ctl_p1      <= ctl_nxt;
            // alu_flags belong to the instruction currently in EX
            if (vld_p1 && !opcode_p1[3])
                flags_p1 <= bus.alu_flags;
        end
    end

    always_ff @(posedge clk) begin
        exec_rd <= exec_rd_nxt;
    end

    assign bus.stall          = stall_c;
    assign bus.redirect       = redirect_c;
    assign bus.exec_req       = exec_req_p1;
    assign bus.ex_valid       = vld_p1;
    assign bus.ex_opcode      = opcode_p1;
    assign bus.ex_rd          = rd_p1;
    assign bus.ex_alu_op      = ctl_p1.alu;
    assign bus.ex_signal      = SIGW'(ctl_p1.sig);
    assign bus.ex_write_en    = ctl_p1.we;
    assign bus.ex_mem_en      = ctl_p1.me;
    assign bus.ex_mem_write_n = ctl_p1.mwn;

endmodule

// File: tb/tb_pipe_control.sv
// tb_pipe_control
// Cycle-by-cycle stimulus records for pipe_control (HAZARD_EN=1) with a
// second HAZARD_EN=0 instance driven identically, plus a hand-written EXEC
// handshake / reset-abort sequence. Expected EX words go through a queue.
module tb_pipe_control;
    localparam int SIGW  = 12;
    localparam int REGAW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_control_if #(.SIGW(SIGW), .REGAW(REGAW)) bus ();
    pipe_control_if #(.SIGW(SIGW), .REGAW(REGAW)) bus0 ();

    pipe_control #(.SIGW(SIGW), .REGAW(REGAW), .HAZARD_EN(1)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    pipe_control #(.SIGW(SIGW), .REGAW(REGAW), .HAZARD_EN(0)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0)
    );

    typedef struct packed {
        logic        v;
        logic [3:0]  op;
        logic [3:0]  rd;
        logic [2:0]  alu;
        logic [11:0] sig;
        logic        we;
        logic        me;
        logic        mwn;
    } exw_t;

    typedef struct {
        logic        r;
        logic        v;
        logic [3:0]  op;
        logic [2:0]  cond;
        logic [3:0]  rs, rt, rd;
        logic [2:0]  fl;
        logic        done;
        logic        cs, es;   // check stall / expected stall
        logic        cr, er;   // check redirect / expected redirect
        logic        h;        // check HAZARD_EN=0 instance never stalls
        logic        ev;       // expected ex_valid after the edge
        logic [11:0] esig;
        logic        ereq;     // expected exec_req after the edge
    } vec_t;

    int   tests = 0;
    int   fails = 0;
    exw_t sb[$];
    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic v, logic [3:0] op, logic [2:0] cond,
                                logic [3:0] rs, logic [3:0] rt, logic [3:0] rd,
                                logic [2:0] fl, logic done, logic cs, logic es,
                                logic cr, logic er, logic h, logic ev,
                                logic [11:0] esig, logic ereq);
        vec_t t;
        t.r = r; t.v = v; t.op = op; t.cond = cond; t.rs = rs; t.rt = rt; t.rd = rd;
        t.fl = fl; t.done = done; t.cs = cs; t.es = es; t.cr = cr; t.er = er;
        t.h = h; t.ev = ev; t.esig = esig; t.ereq = ereq;
        return t;
    endfunction

    function automatic vec_t tv(logic v, logic [3:0] op, logic [2:0] cond,
                                logic [3:0] rs, logic [3:0] rt, logic [3:0] rd,
                                logic [2:0] fl, logic es, logic er, logic ev,
                                logic [11:0] esig);
        return mk(1'b0, v, op, cond, rs, rt, rd, fl, 1'b0, 1'b1, es, 1'b1, er,
                  1'b1, ev, esig, 1'b0);
    endfunction

    // Expected control word from the opcode table; bubble when v=0.
    function automatic exw_t exp_word(logic v, logic [3:0] op, logic [3:0] rd, logic [11:0] sig);
        exw_t w;
        w = '0;
        w.mwn = 1'b1;
        if (v) begin
            w.v = 1'b1; w.op = op; w.rd = rd; w.sig = sig;
            case (op)
                4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin w.alu = op[2:0]; w.we = 1'b1; end
                4'h8: begin w.we = 1'b1; w.me = 1'b1; end
                4'h9: begin w.me = 1'b1; w.mwn = 1'b0; end
                4'hB: begin w.alu = 3'b010; w.we = 1'b1; end
                4'hA, 4'hD, 4'hF: w.we = 1'b1;
                default: ;
            endcase
        end
        return w;
    endfunction

    function automatic exw_t act_word();
        exw_t a;
        a.v = bus.ex_valid; a.op = bus.ex_opcode; a.rd = bus.ex_rd; a.alu = bus.ex_alu_op;
        a.sig = bus.ex_signal; a.we = bus.ex_write_en; a.me = bus.ex_mem_en;
        a.mwn = bus.ex_mem_write_n;
        if (!a.v) begin
            a.op = 4'h0;
            a.rd = 4'h0;
        end
        return a;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        rst = t.r;
        bus.id_valid  = t.v;    bus0.id_valid  = t.v;
        bus.id_opcode = t.op;   bus0.id_opcode = t.op;
        bus.id_cond   = t.cond; bus0.id_cond   = t.cond;
        bus.id_rs     = t.rs;   bus0.id_rs     = t.rs;
        bus.id_rt     = t.rt;   bus0.id_rt     = t.rt;
        bus.id_rd     = t.rd;   bus0.id_rd     = t.rd;
        bus.alu_flags = t.fl;   bus0.alu_flags = t.fl;
        bus.exec_done = t.done; bus0.exec_done = t.done;
    endtask

    task automatic step(input vec_t t, input string tag);
        exw_t e;
        exw_t a;
        drive(t);
        sb.push_back(exp_word(t.ev, t.op, t.rd, t.esig));
        @(negedge clk);
        if (t.cs) check({tag, "_stall"}, 32'(bus.stall), 32'(t.es));
        if (t.cr) check({tag, "_redirect"}, 32'(bus.redirect), 32'(t.er));
        if (t.h)  check({tag, "_nohz_stall"}, 32'(bus0.stall), 32'(0));
        @(posedge clk);
        #1;
        e = sb.pop_front();
        a = act_word();
        check({tag, "_ex_word"}, 32'(a), 32'(e));
        check({tag, "_exec_req"}, 32'(bus.exec_req), 32'(t.ereq));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // ---- reset: outputs hold reset values ----
        for (int i = 0; i < 2; i++)
            step(mk(1'b1, 1'b0, 4'h0, 3'd0, 4'd0, 4'd0, 4'd0, 3'b000, 1'b0,
                    1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 12'h000, 1'b0),
                 $sformatf("reset%0d", i));
        check("reset_opcode_rd", 32'({bus.ex_opcode, bus.ex_rd}), 32'(0));
        check("reset_mem_write_n", 32'(bus.ex_mem_write_n), 32'(1));

        // ---- cycle table: v op cond rs rt rd flags | stall redirect ex_valid ex_signal
        tbl.push_back(tv(1, 4'h0, 3'd0, 4'd2, 4'd3, 4'd1, 3'b000, 0, 0, 1, 12'h036)); // ADD
        tbl.push_back(tv(1, 4'h8, 3'd0, 4'd0, 4'd0, 4'd3, 3'b000, 0, 0, 1, 12'h896)); // LW r3
        tbl.push_back(tv(1, 4'h0, 3'd0, 4'd3, 4'd1, 4'd4, 3'b000, 1, 0, 0, 12'h000)); // ADD rs=3 stalls
        tbl.push_back(tv(1, 4'h0, 3'd0, 4'd3, 4'd1, 4'd4, 3'b000, 0, 0, 1, 12'h036)); // ADD goes
        tbl.push_back(tv(1, 4'h8, 3'd0, 4'd5, 4'd5, 4'd0, 3'b000, 0, 0, 1, 12'h896)); // LW r0
        tbl.push_back(tv(1, 4'h0, 3'd0, 4'd0, 4'd0, 4'd5, 3'b000, 0, 0, 1, 12'h036)); // no stall on r0
        tbl.push_back(tv(1, 4'h1, 3'd0, 4'd1, 4'd2, 4'd6, 3'b000, 0, 0, 1, 12'h036)); // SUB
        tbl.push_back(tv(1, 4'hC, 3'd0, 4'd0, 4'd0, 4'd0, 3'b001, 1, 0, 0, 12'h000)); // B: flag stall, Z=1 loads
        tbl.push_back(tv(1, 4'hC, 3'd0, 4'd0, 4'd0, 4'd0, 3'b001, 0, 1, 1, 12'h031)); // B taken
        tbl.push_back(tv(1, 4'h0, 3'd0, 4'd1, 4'd1, 4'd7, 3'b000, 0, 0, 0, 12'h000)); // killed
        tbl.push_back(tv(1, 4'hC, 3'd1, 4'd0, 4'd0, 4'd0, 3'b000, 0, 0, 1, 12'h030)); // B !Z not taken
        tbl.push_back(tv(1, 4'h3, 3'd0, 4'd1, 4'd2, 4'd2, 3'b000, 0, 0, 1, 12'h036)); // OR, no kill
        tbl.push_back(tv(1, 4'hD, 3'd0, 4'd0, 4'd0, 4'hF, 3'b100, 0, 1, 1, 12'h17D)); // JAL, N=1 loads
        tbl.push_back(tv(1, 4'h9, 3'd0, 4'd1, 4'd2, 4'd0, 3'b000, 0, 0, 0, 12'h000)); // killed SW
        tbl.push_back(tv(1, 4'hC, 3'd3, 4'd0, 4'd0, 4'd0, 3'b000, 0, 1, 1, 12'h031)); // B N taken
        tbl.push_back(tv(1, 4'h8, 3'd0, 4'd1, 4'd0, 4'd4, 3'b000, 0, 0, 0, 12'h000)); // killed LW
        tbl.push_back(tv(1, 4'hE, 3'd0, 4'd5, 4'd0, 4'd0, 3'b000, 0, 1, 1, 12'h17F)); // JR
        tbl.push_back(tv(1, 4'hA, 3'd0, 4'd0, 4'd0, 4'd1, 3'b000, 0, 0, 0, 12'h000)); // killed
        tbl.push_back(tv(1, 4'hA, 3'd0, 4'd0, 4'd0, 4'd1, 3'b000, 0, 0, 1, 12'h500)); // LHB
        tbl.push_back(tv(1, 4'hB, 3'd0, 4'd0, 4'd0, 4'd2, 3'b000, 0, 0, 1, 12'h000)); // LLB
        tbl.push_back(tv(1, 4'h4, 3'd0, 4'd1, 4'd2, 4'd3, 3'b000, 0, 0, 1, 12'h016)); // SLL
        tbl.push_back(tv(0, 4'h0, 3'd0, 4'd0, 4'd0, 4'd0, 3'b010, 0, 0, 0, 12'h000)); // idle
        tbl.push_back(tv(1, 4'h6, 3'd0, 4'd1, 4'd2, 4'd3, 3'b000, 0, 0, 1, 12'h016)); // SRA
        tbl.push_back(tv(1, 4'hC, 3'd7, 4'd0, 4'd0, 4'd0, 3'b010, 1, 0, 0, 12'h000)); // B: flag stall, V=1 loads
        tbl.push_back(tv(1, 4'hC, 3'd7, 4'd0, 4'd0, 4'd0, 3'b000, 0, 1, 1, 12'h031)); // always
        tbl.push_back(tv(1, 4'hC, 3'd6, 4'd0, 4'd0, 4'd0, 3'b000, 0, 0, 0, 12'h000)); // killed
        tbl.push_back(tv(1, 4'hC, 3'd6, 4'd0, 4'd0, 4'd0, 3'b000, 0, 1, 1, 12'h031)); // V taken
        tbl.push_back(tv(1, 4'h0, 3'd0, 4'd0, 4'd0, 4'd1, 3'b000, 0, 0, 0, 12'h000)); // killed
        tbl.push_back(tv(1, 4'hC, 3'd5, 4'd0, 4'd0, 4'd0, 3'b000, 0, 0, 1, 12'h030)); // Z|N false
        tbl.push_back(tv(1, 4'hC, 3'd2, 4'd0, 4'd0, 4'd0, 3'b000, 0, 1, 1, 12'h031)); // !Z&!N taken
        tbl.push_back(tv(1, 4'h1, 3'd0, 4'd0, 4'd0, 4'd1, 3'b000, 0, 0, 0, 12'h000)); // killed
        tbl.push_back(tv(1, 4'h8, 3'd0, 4'd0, 4'd0, 4'd2, 3'b000, 0, 0, 1, 12'h896)); // LW r2
        tbl.push_back(tv(1, 4'h2, 3'd0, 4'd7, 4'd2, 4'd1, 3'b000, 1, 0, 0, 12'h000)); // AND rt=2 stalls
        tbl.push_back(tv(1, 4'h2, 3'd0, 4'd7, 4'd2, 4'd1, 3'b000, 0, 0, 1, 12'h036)); // AND goes
        tbl.push_back(tv(0, 4'h0, 3'd0, 4'd0, 4'd0, 4'd0, 3'b001, 0, 0, 0, 12'h000)); // Z=1 loads
        tbl.push_back(tv(1, 4'hC, 3'd4, 4'd0, 4'd0, 4'd0, 3'b000, 0, 1, 1, 12'h031)); // Z|(!Z&!N)
        tbl.push_back(tv(1, 4'h0, 3'd0, 4'd0, 4'd0, 4'd1, 3'b000, 0, 0, 0, 12'h000)); // killed
        tbl.push_back(tv(1, 4'hC, 3'd0, 4'd0, 4'd0, 4'd0, 3'b000, 0, 1, 1, 12'h031)); // Z taken
        tbl.push_back(tv(0, 4'h0, 3'd0, 4'd0, 4'd0, 4'd0, 3'b000, 0, 0, 0, 12'h000)); // kill slot
        tbl.push_back(tv(0, 4'h0, 3'd0, 4'd0, 4'd0, 4'd0, 3'b000, 0, 0, 0, 12'h000)); // idle

        for (int i = 0; i < tbl.size(); i++)
            step(tbl[i], $sformatf("vec%0d", i));

        // ---- EXEC: exec_req rises, exec_done four cycles later ----
        step(mk(0, 1, 4'hF, 3'd0, 4'd0, 4'd0, 4'd9, 3'b000, 0, 0, 0, 1, 0, 0, 0, 12'h000, 1), "exec_enter");
        for (int i = 0; i < 4; i++)
            step(mk(0, 1, 4'hF, 3'd0, 4'd0, 4'd0, 4'd9, 3'b000, 0, 1, 1, 1, 0, 0, 0, 12'h000, 1),
                 $sformatf("exec_wait%0d", i));
        step(mk(0, 1, 4'hF, 3'd0, 4'd0, 4'd0, 4'd9, 3'b000, 1, 1, 1, 1, 0, 0, 1, 12'h137, 0), "exec_done");
        // exec_done while idle has no effect
        step(mk(0, 1, 4'h0, 3'd0, 4'd1, 4'd2, 4'd3, 3'b000, 1, 1, 0, 1, 0, 0, 1, 12'h036, 0), "idle_done");

        // ---- reset during EXEC_WAIT abandons the request ----
        step(mk(0, 1, 4'hF, 3'd0, 4'd0, 4'd0, 4'hA, 3'b000, 0, 0, 0, 1, 0, 0, 0, 12'h000, 1), "exec2_enter");
        step(mk(0, 1, 4'hF, 3'd0, 4'd0, 4'd0, 4'hA, 3'b000, 0, 1, 1, 1, 0, 0, 0, 12'h000, 1), "exec2_wait");
        step(mk(1, 1, 4'hF, 3'd0, 4'd0, 4'd0, 4'hA, 3'b000, 0, 0, 0, 0, 0, 0, 0, 12'h000, 0), "exec2_rst");
        step(mk(0, 0, 4'h0, 3'd0, 4'd0, 4'd0, 4'd0, 3'b000, 0, 1, 0, 1, 0, 0, 0, 12'h000, 0), "post_rst");
        step(mk(0, 1, 4'h0, 3'd0, 4'd1, 4'd2, 4'd4, 3'b000, 0, 1, 0, 1, 0, 0, 1, 12'h036, 0), "post_rst_add");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
